line_buffer_feeder: RTL and testbench

//  Row-fetch sequencer that drives the 10-row line buffer: issues SRAM row reads, aligns

---
 rtl/line_buffer_feeder.sv | 136 +++++++++++++
 tb/tb_line_buffer_feeder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_feeder.sv
// Row-fetch sequencer for the 10-row line buffer: SRAM row reads, latency-aligned buffer_we,
// bottom zero-padding and window-centre reporting. Define LB_FEEDER_PERF_EN to add stall_cycles_o.
module line_buffer_feeder #(
    parameter int ADDR_W   = 9,
    parameter int IMG_ROWS = 240,
    parameter int PAD_ROWS = 3,
    parameter int SRAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        mode_i,
    input  logic [ADDR_W-1:0] row_base_i,
    input  logic              stall_i,
    output logic              sram_re_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [2:0]        buffer_mode_o,
    output logic              buffer_we_o,
    output logic              fill_zero_o,
    output logic              row_valid_o,
    output logic [ADDR_W-1:0] center_row_o,
    output logic              busy_o,
    output logic              done_o,
`ifdef LB_FEEDER_PERF_EN
    output logic [31:0]       stall_cycles_o,
`endif
    output logic [2:0]        state_o
);
    localparam int CW = ADDR_W + 1;
    localparam int WW = ADDR_W + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_PAD   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Handshake: start_i is a single-cycle request, accepted only in IDLE with mode 1 or 2;
    // stall_i is level-sensitive and blocks new sram_re/fill_zero in the same cycle.
    logic [2:0]          state_q, state_d;
    logic [2:0]          mode_q;
    logic [ADDR_W-1:0]   base_q;
    logic [CW-1:0]       rd_cnt_q;
    logic [WW-1:0]       wr_cnt_q;
    logic [WW-1:0]       pad_cnt_q;
    logic [SRAM_LAT-1:0] re_pipe_q;
    logic [SRAM_LAT:0]   re_shift;
    logic                row_valid_q, row_valid_d;
    logic [ADDR_W-1:0]   center_q, center_d;
    logic [WW-1:0]       center_full;
    logic                accept, gauss, running, sram_re, buffer_we, fill_zero, write_row;

    assign gauss     = (mode_q == 3'd1);
    assign running   = (state_q == S_FETCH) || (state_q == S_PAD) || (state_q == S_DRAIN);
    assign accept    = (state_q == S_IDLE) && start_i && ((mode_i == 3'd1) || (mode_i == 3'd2));
    assign sram_re   = (state_q == S_FETCH) && !stall_i && (rd_cnt_q < CW'(IMG_ROWS));
    assign buffer_we = re_pipe_q[SRAM_LAT-1];
    assign fill_zero = (state_q == S_PAD) && !stall_i;
    assign write_row = buffer_we || fill_zero;
    assign re_shift  = {re_pipe_q, sram_re};

    // In Gaussian mode the window centre trails the newest written row by PAD_ROWS.
    always_comb begin
        center_full = gauss ? (wr_cnt_q - WW'(PAD_ROWS)) : wr_cnt_q;
        center_d    = center_full[ADDR_W-1:0];
        row_valid_d = write_row && (!gauss || (wr_cnt_q >= WW'(PAD_ROWS)));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_FETCH;
            S_FETCH: if (buffer_we && (wr_cnt_q == WW'(IMG_ROWS - 1)))
                         state_d = gauss ? S_PAD : S_DRAIN;
            S_PAD:   if (fill_zero && (pad_cnt_q == WW'(PAD_ROWS - 1))) state_d = S_DRAIN;
            S_DRAIN: if (row_valid_q && (center_q == ADDR_W'(IMG_ROWS - 1))) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 3'd0;
            base_q      <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            pad_cnt_q   <= '0;
            re_pipe_q   <= '0;
            row_valid_q <= 1'b0;
            center_q    <= '0;
        end else begin
            state_q     <= state_d;
            re_pipe_q   <= re_shift[SRAM_LAT-1:0];
            row_valid_q <= row_valid_d;
            if (write_row) center_q <= center_d;
            if (accept) begin
                mode_q    <= mode_i;
                base_q    <= row_base_i;
                rd_cnt_q  <= '0;
                wr_cnt_q  <= '0;
                pad_cnt_q <= '0;
            end else begin
                if (sram_re)   rd_cnt_q  <= rd_cnt_q + CW'(1);
                if (write_row) wr_cnt_q  <= wr_cnt_q + WW'(1);
                if (fill_zero) pad_cnt_q <= pad_cnt_q + WW'(1);
            end
        end
    end

`ifdef LB_FEEDER_PERF_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (accept) begin
            stall_cnt_q <= '0;
        end else if (running && stall_i && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
    assign stall_cycles_o = stall_cnt_q;
`endif

    assign sram_re_o     = sram_re;
    assign sram_addr_o   = sram_re ? (base_q + rd_cnt_q[ADDR_W-1:0]) : '0;
    assign buffer_mode_o = running ? mode_q : 3'd0;
    assign buffer_we_o   = buffer_we;
    assign fill_zero_o   = fill_zero;
    assign row_valid_o   = row_valid_q;
    assign center_row_o  = center_q;
    assign busy_o        = running;
    assign done_o        = (state_q == S_DONE);
    assign state_o       = state_q;
endmodule

// File: tb/tb_line_buffer_feeder.sv
// Self-checking bench for line_buffer_feeder (IMG_ROWS=8, PAD_ROWS=3, SRAM_LAT=1, ADDR_W=9).
module tb_line_buffer_feeder;
  localparam int AW = 9, N = 8, PAD = 3, LAT = 1, MAXC = 128;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [AW-1:0] row_base = '0;
  logic sram_re, buffer_we, fill_zero, row_valid, busy, done;
  logic [AW-1:0] sram_addr, center_row;
  logic [2:0] buffer_mode, state_dbg;
`ifdef LB_FEEDER_PERF_EN
  logic [31:0] stall_cycles;
`endif

  line_buffer_feeder #(.ADDR_W(AW), .IMG_ROWS(N), .PAD_ROWS(PAD), .SRAM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .row_base_i(row_base),
    .stall_i(stall), .sram_re_o(sram_re), .sram_addr_o(sram_addr), .buffer_mode_o(buffer_mode),
    .buffer_we_o(buffer_we), .fill_zero_o(fill_zero), .row_valid_o(row_valid),
    .center_row_o(center_row), .busy_o(busy), .done_o(done),
`ifdef LB_FEEDER_PERF_EN
    .stall_cycles_o(stall_cycles),
`endif
    .state_o(state_dbg));

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests_run = 0, tests_failed = 0;

  // reference trace of one run, indexed by cycle (cycle 0 = start asserted)
  bit stl[MAXC];
  bit e_re[MAXC], e_we[MAXC], e_fz[MAXC], e_rv[MAXC];
  logic [AW-1:0] e_addr[MAXC], e_ctr[MAXC];
  int e_done, e_first_rv;
  logic [AW-1:0] exp_q[$];

  // observed facts from the last run
  int dut_done_cyc, dut_first_rv, dut_rv_cnt;
  logic [AW-1:0] dut_addr3;
  int perf_exp;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Trace model: reads on free cycles, writes LAT later, pads after the last write,
  // a window valid the cycle after row r+PAD (Gaussian) or row r (detect) lands.
  task automatic plan(input bit gauss, input logic [AW-1:0] base);
    int c, issued, p, k, last_we;
    for (int i = 0; i < MAXC; i++) begin
      e_re[i] = 0; e_we[i] = 0; e_fz[i] = 0; e_rv[i] = 0; e_addr[i] = '0; e_ctr[i] = '0;
    end
    c = 1; issued = 0;
    while (issued < N) begin
      if (!stl[c]) begin
        e_re[c] = 1; e_addr[c] = base + AW'(issued); issued++;
      end
      c++;
    end
    last_we = 0;
    for (int i = 0; i + LAT < MAXC; i++) begin
      e_we[i + LAT] = e_re[i];
      if (e_re[i]) last_we = i + LAT;
    end
    if (gauss) begin
      c = last_we + 1; p = 0;
      while (p < PAD) begin
        if (!stl[c]) begin e_fz[c] = 1; p++; end
        c++;
      end
    end
    k = 0; e_done = 0; e_first_rv = -1;
    for (int i = 0; i + 1 < MAXC; i++) begin
      if (e_we[i] || e_fz[i]) begin
        if (!gauss || k >= PAD) begin
          e_rv[i + 1] = 1;
          e_ctr[i + 1] = gauss ? AW'(k - PAD) : AW'(k);
          e_done = i + 2;
          if (e_first_rv < 0) e_first_rv = i + 1;
        end
        k++;
      end
    end
  endtask

  task automatic fill_stall(input int pct);
    for (int i = 0; i < MAXC; i++) stl[i] = (i >= 1 && i < 40) ? ($urandom_range(99) < pct) : 1'b0;
  endtask

  // driver + per-cycle compare; caller has filled stl[]
  task automatic run(input logic [2:0] m, input logic [AW-1:0] base, input int extra_start);
    bit gauss, b_exp;
    gauss = (m == 3'd1);
    plan(gauss, base);
    exp_q.delete();
    for (int i = 0; i < MAXC; i++) if (e_rv[i]) exp_q.push_back(e_ctr[i]);
    perf_exp = 0; dut_done_cyc = -1; dut_first_rv = -1; dut_rv_cnt = 0; dut_addr3 = '0;
    for (int c = 0; c <= e_done + 1; c++) begin
      start = (c == 0) || (c == extra_start);
      mode = m;
      row_base = (c == 0) ? base : AW'($urandom);
      stall = stl[c];
      @(negedge clk);
      b_exp = (c >= 1) && (c < e_done);
      check("sram_re", c, sram_re, e_re[c]);
      check("sram_addr", c, sram_addr, e_re[c] ? e_addr[c] : '0);
      check("buffer_we", c, buffer_we, e_we[c]);
      check("fill_zero", c, fill_zero, e_fz[c]);
      check("row_valid", c, row_valid, e_rv[c]);
      check("busy", c, busy, b_exp);
      check("done", c, done, c == e_done);
      check("buffer_mode", c, buffer_mode, b_exp ? m : 3'd0);
      if (row_valid === 1'b1) begin
        dut_rv_cnt++;
        if (dut_first_rv < 0) dut_first_rv = c;
        if (exp_q.size() == 0) check("center_row_extra", c, center_row, '1);
        else check("center_row", c, center_row, exp_q.pop_front());
      end
      if (done === 1'b1 && dut_done_cyc < 0) dut_done_cyc = c;
      if (c == 3) dut_addr3 = sram_addr;
`ifdef LB_FEEDER_PERF_EN
      if (c >= 1) check("stall_cycles", c, stall_cycles, perf_exp);
      if (b_exp && stl[c]) perf_exp++;
`endif
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0;
    check("rows_left_in_queue", e_done, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sram_re"}, 0, sram_re, 0);
    check({tag, "_sram_addr"}, 0, sram_addr, 0);
    check({tag, "_buffer_mode"}, 0, buffer_mode, 0);
    check({tag, "_buffer_we"}, 0, buffer_we, 0);
    check({tag, "_fill_zero"}, 0, fill_zero, 0);
    check({tag, "_row_valid"}, 0, row_valid, 0);
    check({tag, "_center_row"}, 0, center_row, 0);
    check({tag, "_busy"}, 0, busy, 0);
    check({tag, "_done"}, 0, done, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // mid-run reset at cycle 5: outputs drop at once, no done
    start = 1'b1; mode = 3'd1; row_base = 9'h010;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_busy", 5, busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_in_reset", i, done, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Gaussian, base 0x010, no stall
    fill_stall(0);
    run(3'd1, 9'h010, -1);
    check("g_done_cycle", 0, dut_done_cyc, 14);
    check("g_first_rv", 0, dut_first_rv, 6);
    check("g_rv_count", 0, dut_rv_cnt, 8);
    check("model_g_done", 0, e_done, 14);

    // Gaussian, stall cycles 3-4
    fill_stall(0);
    stl[3] = 1; stl[4] = 1;
    run(3'd1, 9'h020, -1);
    check("gs_done_cycle", 0, dut_done_cyc, 16);
    check("gs_rv_count", 0, dut_rv_cnt, 8);
    check("model_gs_done", 0, e_done, 16);
`ifdef LB_FEEDER_PERF_EN
    check("perf_after_done", 0, stall_cycles, 2);
`endif

    // Detect with address wrap
    fill_stall(0);
    run(3'd2, 9'h1FE, -1);
    check("d_addr_wrap", 3, dut_addr3, 9'h000);
    check("d_first_rv", 0, dut_first_rv, 3);
    check("d_done_cycle", 0, dut_done_cyc, 11);
    check("model_d_first_rv", 0, e_first_rv, 3);

    // unsupported mode is ignored
    start = 1'b1; mode = 3'd3; row_base = 9'h055;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mode3_busy", i, busy, 0);
      check("mode3_sram_re", i, sram_re, 0);
      @(posedge clk); #1;
    end

    // start during a run is ignored
    fill_stall(0);
    run(3'd1, 9'h010, 4);
    check("restart_ignored_done", 0, dut_done_cyc, 14);

    // randomized runs
    for (int t = 0; t < 24; t++) begin
      fill_stall($urandom_range(50));
      run(($urandom_range(1) == 0) ? 3'd1 : 3'd2, AW'($urandom), ($urandom_range(3) == 0) ? $urandom_range(1, 10) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
